// File: rtl/deser_frame_scheduler.sv
// Round-robin frame scheduler feeding a deserializer: grants one requester for N beats,
// then waits for the frame-complete strobe. Optional watchdog: DESER_SCHED_TIMEOUT_EN.
module deser_frame_scheduler #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [M-1:0]            i_req,
  input  logic [M*DATA_WIDTH-1:0] i_data,
  output logic [M-1:0]            o_gnt,
  output logic                    o_deser_enb,
  output logic [DATA_WIDTH-1:0]   o_deser_data,
  input  logic                    i_deser_valid,
  output logic                    o_frame_done,
  output logic [$clog2(M)-1:0]    o_frame_src,
  output logic                    o_timeout
);

  localparam int SW = $clog2(M);
  localparam int BW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, XFER, WAIT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] last_q, last_d;
  logic          done_q, done_d;
  logic [SW-1:0] win;
  logic          found;

`ifdef DESER_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;
`endif

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int i = 1; i <= M; i++) begin
      if (!found && i_req[(int'(last_q) + i) % M]) begin
        win   = SW'((int'(last_q) + i) % M);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold/default value first so no path infers a latch.
    state_d = state_q;
    beat_d  = beat_q;
    src_d   = src_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef DESER_SCHED_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          src_d   = win;
          last_d  = win;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat_q == BW'(N - 1)) begin
          beat_d  = '0;
          state_d = WAIT;
`ifdef DESER_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WAIT: begin
        if (i_deser_valid) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef DESER_SCHED_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      src_q   <= '0;
      last_q  <= SW'(M - 1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      src_q   <= src_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef DESER_SCHED_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_deser_enb  = (state_q == XFER);
  assign o_gnt        = o_deser_enb ? ({{(M-1){1'b0}}, 1'b1} << src_q) : '0;
  assign o_deser_data = o_deser_enb ? i_data[int'(src_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_frame_done = done_q;
  assign o_frame_src  = src_q;

endmodule
